// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the 3-bit controller state
// encoding, plus the next-state function used by the FIFO controller. The
// multiplier datapath imports the same package so both sides agree on the
// FIFO depth, word width and state codes.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;   // entries, power of two
  localparam int FIFO_WIDTH = 32;  // bits per entry

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    WR_ERROR = 3'd3,
    READ     = 3'd4,
    RD_ERROR = 3'd5
  } fifo_state_t;

  // A lone write goes to WRITE or WR_ERROR depending on full; a lone read
  // goes to READ or RD_ERROR depending on empty. Anything else, including
  // a simultaneous write and read, is ignored.
  function automatic fifo_state_t next_state(input logic wr,
                                             input logic rd,
                                             input logic is_full,
                                             input logic is_empty);
    fifo_state_t ns;
    ns = NO_OP;
    if (wr && !rd) begin
      ns = is_full ? WR_ERROR : WRITE;
    end else if (rd && !wr) begin
      ns = is_empty ? RD_ERROR : READ;
    end
    return ns;
  endfunction

endpackage

// File: rtl/fifo_register_file.sv
// FIFO storage array: DEPTH x WIDTH, synchronous write, synchronous
// registered read port.
//   clk     - clock
//   reset_n - asynchronous active-low reset (clears the read register only)
//   wr_en   - write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr - write address
//   wr_data - write data
//   rd_en   - read strobe, mem[rd_addr] loaded into rd_data on the edge
//   rd_addr - read address
//   rd_data - registered read data, holds its value when rd_en is low
module fifo_register_file
  import fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is never reset: a slot is only readable after it was written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo.sv
// Synchronous FIFO with a six-state request controller and per-request
// status flags.
//   clk        - sole clock, rising edge
//   reset_n    - asynchronous active-low reset
//   wr_en      - write request this cycle
//   rd_en      - read request this cycle (both together are ignored)
//   din        - write data, sampled with wr_en
//   dout       - registered read data, one-edge latency, holds otherwise
//   data_count - number of occupied entries, 0..DEPTH
//   full       - data_count == DEPTH
//   empty      - data_count == 0
//   wr_ack     - previous edge accepted a write
//   wr_err     - previous edge rejected a write (FIFO was full)
//   rd_ack     - previous edge performed a read
//   rd_err     - previous edge rejected a read (FIFO was empty)
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     data_count,
  output logic                       full,
  output logic                       empty,
  output logic                       wr_ack,
  output logic                       wr_err,
  output logic                       rd_ack,
  output logic                       rd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fifo_state_t      state, state_nxt;
  logic [PTR_W-1:0] head, head_nxt;
  logic [PTR_W-1:0] tail, tail_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             do_wr, do_rd;

  assign full  = (data_count == CNT_W'(DEPTH));
  assign empty = (data_count == '0);

  // Next state and pointer/count update. Memory write, pointer advance and
  // count change all happen on the edge that enters WRITE/READ. Pointers
  // are PTR_W bits wide so they wrap DEPTH-1 -> 0 by themselves.
  always_comb begin
    state_nxt = next_state(wr_en, rd_en, full, empty);
    do_wr     = (state_nxt == WRITE);
    do_rd     = (state_nxt == READ);
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = data_count;
    if (do_wr) begin
      tail_nxt  = tail + PTR_W'(1);
      count_nxt = data_count + CNT_W'(1);
    end else if (do_rd) begin
      head_nxt  = head + PTR_W'(1);
      count_nxt = data_count - CNT_W'(1);
    end
  end

  // Status flags decode the registered state only.
  always_comb begin
    wr_ack = (state == WRITE);
    wr_err = (state == WR_ERROR);
    rd_ack = (state == READ);
    rd_err = (state == RD_ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
    end else begin
      state      <= state_nxt;
      head       <= head_nxt;
      tail       <= tail_nxt;
      data_count <= count_nxt;
    end
  end

  fifo_register_file #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (PTR_W)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (do_wr),
    .wr_addr (tail),
    .wr_data (din),
    .rd_en   (do_rd),
    .rd_addr (head),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [31:0] din;
  logic [31:0] dout;
  logic [3:0]  data_count;
  logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;

  always #5 clk = ~clk;

  fifo dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] sb[$];
  logic [31:0] m_dout;
  logic        m_wack, m_werr, m_rack, m_rerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    c = sb.size();
    chk({tag, "_cnt"},   32'(data_count), 32'(c));
    chk({tag, "_full"},  32'(full),       32'(c == 8));
    chk({tag, "_empty"}, 32'(empty),      32'(c == 0));
    chk({tag, "_dout"},  dout,            m_dout);
    chk({tag, "_wack"},  32'(wr_ack),     32'(m_wack));
    chk({tag, "_werr"},  32'(wr_err),     32'(m_werr));
    chk({tag, "_rack"},  32'(rd_ack),     32'(m_rack));
    chk({tag, "_rerr"},  32'(rd_err),     32'(m_rerr));
  endtask

  // Drive one cycle of requests, update the scoreboard, check after the edge.
  task automatic step(input string tag, input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
    if (w && !r) begin
      if (sb.size() < 8) begin
        sb.push_back(d);
        m_wack = 1'b1;
      end else begin
        m_werr = 1'b1;
      end
    end else if (r && !w) begin
      if (sb.size() > 0) begin
        m_dout = sb.pop_front();
        m_rack = 1'b1;
      end else begin
        m_rerr = 1'b1;
      end
    end
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    m_dout  = '0;
    m_wack  = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
    #12;
    check_all("rst");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 32'hdead_beef);

    // Fill with 1..8, then one write too many.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, 32'(i));
    step("wr_full", 1'b1, 1'b0, 32'h0000_0009);

    // Drain in order, then one read too many.
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, '0);
    step("rd_empty", 1'b0, 1'b1, '0);

    // Pointer wrap: write 5, read 5, write 6, read 6.
    for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) step("wrap_w6", 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 6; i++) step("wrap_r6", 1'b0, 1'b1, '0);

    // Simultaneous requests at count 3 are ignored.
    for (int i = 0; i < 3; i++) step("pre_both", 1'b1, 1'b0, 32'h100 + 32'(i));
    step("both0", 1'b1, 1'b1, 32'hffff_ffff);
    step("both1", 1'b1, 1'b1, 32'heeee_eeee);

    // Fill, reject, read one, and write again right after full drops.
    for (int i = 0; i < 5; i++) step("refill", 1'b1, 1'b0, $urandom);
    step("wr_full2", 1'b1, 1'b0, 32'h5555_5555);
    step("rd_one", 1'b0, 1'b1, '0);
    step("wr_after_full", 1'b1, 1'b0, 32'ha5a5_a5a5);
    for (int i = 0; i < 4; i++) step("to_four", 1'b0, 1'b1, '0);

    // Asynchronous reset at count 4, away from any clock edge.
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    m_dout = '0;
    m_wack = 1'b0; m_werr = 1'b0; m_rack = 1'b0; m_rerr = 1'b0;
    check_all("rst_async");
    #3;
    reset_n = 1'b1;
    step("post_rst_rd", 1'b0, 1'b1, '0);
    step("post_rst_wr", 1'b1, 1'b0, 32'h1234_5678);
    step("post_rst_rd2", 1'b0, 1'b1, '0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, number of 32-bit entries (fixed power of two).
REQ-002 The block SHALL have parameter WIDTH, default 32, data word width.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port wr_en  input  1  write request for the current cycle.
REQ-006 Port rd_en  input  1  read request for the current cycle.
REQ-007 Port din  input  WIDTH  write data, sampled with wr_en.
REQ-008 Port dout  output  WIDTH  registered read data.
REQ-009 Port data_count  output  4  occupied entries, 0..8; drives the multiplier's fifo_data_count0/1.
REQ-010 Port full  output  1  high when data_count==8.
REQ-011 Port empty  output  1  high when data_count==0.
REQ-012 Ports wr_ack, wr_err, rd_ack, rd_err  output  1 each  one-cycle status of the previous request.

Function
REQ-013 The FSM SHALL have six states: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR; next state is chosen every edge from wr_en, rd_en and data_count.
REQ-014 Transitions: wr_en&!rd_en & !full -> WRITE; wr_en&!rd_en & full -> WR_ERROR; rd_en&!wr_en & !empty -> READ; rd_en&!wr_en & empty -> RD_ERROR; otherwise -> NO_OP.
REQ-015 Simultaneous wr_en&rd_en SHALL be ignored (NO_OP): no memory, pointer, count or dout change; no ack/err.
REQ-016 On entering WRITE: mem[tail]<=din, tail<=tail+1 mod 8, data_count+1, all at the same edge.
REQ-017 On entering READ: dout<=mem[head], head<=head+1 mod 8, data_count-1, all at the same edge; read latency is one edge.
REQ-018 Pointers SHALL be 3 bits and wrap 7->0 with no other effect.
REQ-019 wr_ack=1 only in WRITE, wr_err=1 only in WR_ERROR, rd_ack=1 only in READ, rd_err=1 only in RD_ERROR; all are decoded from state alone.
REQ-020 WR_ERROR and RD_ERROR SHALL change no memory, pointer, count or dout.
REQ-021 dout SHALL hold its last read value in every non-READ state.
REQ-022 full and empty SHALL be combinational from the registered data_count; they are never both high.
REQ-023 Back-to-back requests SHALL be accepted every cycle; a write in the cycle after full deasserts is accepted.

Reset
REQ-024 reset_n low SHALL immediately force: state INIT, head=tail=0, data_count=0, dout=0, all ack/err=0, empty=1, full=0.
REQ-025 Memory contents need not be cleared; they are unreachable until rewritten.
REQ-026 A reset asserted mid-traffic SHALL discard all stored entries; the first edge after release follows REQ-014 from INIT.
REQ-027 INIT SHALL behave as NO_OP for outputs.

Structure
REQ-028 State encodings (3 bits), DEPTH and WIDTH SHALL live in the shared package used by the multiplier datapath.
REQ-029 Storage SHALL be a separate sub-module, fifo_register_file: 8x32, synchronous write, synchronous registered read port.
REQ-030 Next-state/pointer logic, output decode and flip-flops SHALL be separate always blocks or instances, mirroring the multiplier's ns/cal/out split.

Verification
REQ-031 Reset, then idle 3 cycles -> data_count=0, empty=1, full=0, dout=0, all ack/err=0.
REQ-032 Write 0x00000001..0x00000008 on consecutive cycles -> wr_ack high 8 cycles, data_count 1..8, full=1 after the 8th; a 9th write -> wr_err=1 for one cycle, count stays 8.
REQ-033 Then 8 consecutive reads -> dout 0x00000001..0x00000008 in order, one per cycle with rd_ack; empty=1 after; a 9th read -> rd_err=1, dout stays 0x00000008.
REQ-034 Write 5, read 5, write 6 more -> tail wraps past 7, reads return the 6 values in order, count reaches 0.
REQ-035 Count=3, drive wr_en=rd_en=1 for 2 cycles -> count stays 3, no ack/err, dout unchanged.
REQ-036 Count=4, assert reset_n low mid-cycle -> outputs clear without waiting for clk; after release, a read gives rd_err.
